// File: rtl/nand_lane_fifo.sv
// nand_lane_fifo: bitwise NAND/AND/NOR/OR reduction of LANES x WIDTH words into a DEPTH-entry valid/ready FIFO.
// Optional define NAND_LANE_FIFO_PARITY_EN stores an even-parity bit per entry and presents it on out_parity.
module nand_lane_fifo #(
    parameter int LANES = 4,
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH-1:0]     in_data,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
`ifdef NAND_LANE_FIFO_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef NAND_LANE_FIFO_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    // Full when the pointers differ only in the wrap bit.
    localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

    localparam logic [1:0] MODE_NAND = 2'b00;
    localparam logic [1:0] MODE_AND  = 2'b01;
    localparam logic [1:0] MODE_NOR  = 2'b10;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] and_red, or_red, result;
    logic [EW-1:0]    entry;
    logic             push, pop, empty;

    always_comb begin
        and_red = '1;
        or_red  = '0;
        for (int k = 0; k < LANES; k++) begin
            and_red = and_red & in_data[k*WIDTH +: WIDTH];
            or_red  = or_red | in_data[k*WIDTH +: WIDTH];
        end
        case (in_mode)
            MODE_NAND: result = ~and_red;
            MODE_AND:  result = and_red;
            MODE_NOR:  result = ~or_red;
            default:   result = or_red;
        endcase
`ifdef NAND_LANE_FIFO_PARITY_EN
        entry = {^result, result};
`else
        entry = result;
`endif
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = in_valid && in_ready_q;
    assign pop   = !empty && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = entry;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Registered ready: derived from next-state pointers, so no path from out_ready.
        in_ready_d = ((wr_ptr_d ^ rd_ptr_d) != FULL_XOR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]][WIDTH-1:0];
    assign count     = count_q;
`ifdef NAND_LANE_FIFO_PARITY_EN
    assign out_parity = mem_q[rd_ptr_q[AW-1:0]][WIDTH];
`endif

endmodule

// File: tb/tb_nand_lane_fifo.sv
// tb_nand_lane_fifo: table-driven vectors plus hand sequences, checked against a queue scoreboard.
// Builds with or without NAND_LANE_FIFO_PARITY_EN; parity is checked when the define is present.
module tb_nand_lane_fifo;
    localparam int LANES = 4;
    localparam int WIDTH = 6;
    localparam int DEPTH = 4;
    localparam int DW    = LANES * WIDTH;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
`ifdef NAND_LANE_FIFO_PARITY_EN
    logic             out_parity;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] cur_exp;

    typedef struct {
        logic [DW-1:0]    data;
        logic [1:0]       mode;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    nand_lane_fifo #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef NAND_LANE_FIFO_PARITY_EN
        .out_parity(out_parity),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] refReduce(input logic [DW-1:0] d, input logic [1:0] m);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] o;
        a = '1;
        o = '0;
        for (int k = 0; k < LANES; k++) begin
            a = a & d[k*WIDTH +: WIDTH];
            o = o | d[k*WIDTH +: WIDTH];
        end
        case (m)
            2'b00:   return ~a;
            2'b01:   return a;
            2'b10:   return ~o;
            default: return o;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [1:0] m, input logic [WIDTH-1:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        cur_exp  = e;
    endtask

    task automatic pushRandom();
        logic [DW-1:0] d;
        logic [1:0]    m;
        d = DW'($urandom());
        m = 2'($urandom_range(0, 3));
        applyStimulus(d, m, refReduce(d, m));
    endtask

    task automatic drainWait();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        checkOutput("drain_count", 32'(count), 32'd0);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Scoreboard: sample between edges; pops are compared before this cycle's push is queued.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_count", 32'(count), 32'd0);
            checkOutput("rst_out_data", 32'(out_data), 32'd0);
        end else begin
            checkOutput("count", 32'(count), 32'(exp_q.size()));
            checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(e));
`ifdef NAND_LANE_FIFO_PARITY_EN
                checkOutput("out_parity", 32'(out_parity), 32'(^e));
`endif
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    initial begin
        vecs[0] = '{ {6'h0F, 6'h3F, 6'h3F, 6'h3F}, 2'b00, 6'h30 };
        vecs[1] = '{ {6'h3F, 6'h3F, 6'h3F, 6'h3F}, 2'b00, 6'h00 };
        vecs[2] = '{ {6'h00, 6'h00, 6'h00, 6'h00}, 2'b00, 6'h3F };
        vecs[3] = '{ {6'h00, 6'h00, 6'h00, 6'h00}, 2'b01, 6'h00 };
        vecs[4] = '{ {6'h00, 6'h00, 6'h00, 6'h00}, 2'b10, 6'h3F };
        vecs[5] = '{ {6'h00, 6'h00, 6'h00, 6'h00}, 2'b11, 6'h00 };
        vecs[6] = '{ {6'h08, 6'h04, 6'h02, 6'h01}, 2'b11, 6'h0F };
        vecs[7] = '{ {6'h08, 6'h04, 6'h02, 6'h01}, 2'b10, 6'h30 };
        vecs[8] = '{ {6'h08, 6'h04, 6'h02, 6'h01}, 2'b00, 6'h3F };
        vecs[9] = '{ {6'h3F, 6'h3F, 6'h3F, 6'h31}, 2'b01, 6'h31 };

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        cur_exp   = '0;

        repeat (3) step();
        rst_n = 1'b1;
        step();
        $display("[TB] reset and idle");
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_out_data", 32'(out_data), 32'd0);
        checkOutput("idle_count", 32'(count), 32'd0);

        $display("[TB] single-beat latency");
        applyStimulus(vecs[0].data, vecs[0].mode, vecs[0].exp);
        step();
        in_valid = 1'b0;
        checkOutput("lat_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_out_data", 32'(out_data), 32'h30);
        drainWait();

        $display("[TB] vector table, streaming");
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].data, vecs[i].mode, vecs[i].exp);
            step();
        end
        drainWait();

        $display("[TB] fill and back-pressure");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pushRandom();
            step();
            if (i == 3) begin
                checkOutput("full_count", 32'(count), 32'd4);
                checkOutput("full_in_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        checkOutput("fifth_not_stored", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        checkOutput("ready_after_pop", 32'(in_ready), 32'd1);
        drainWait();

        $display("[TB] simultaneous push/pop with wrap");
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pushRandom();
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pushRandom();
            step();
            checkOutput("steady_count", 32'(count), 32'd2);
        end
        drainWait();

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pushRandom();
            step();
        end
        in_valid = 1'b0;
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_count", 32'(count), 32'd0);
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        applyStimulus(vecs[9].data, vecs[9].mode, vecs[9].exp);
        step();
        in_valid = 1'b0;
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd1);
        checkOutput("post_rst_out_data", 32'(out_data), 32'h31);
`ifdef NAND_LANE_FIFO_PARITY_EN
        checkOutput("post_rst_parity", 32'(out_parity), 32'd1);
`endif
        out_ready = 1'b1;
        applyStimulus(vecs[0].data, vecs[0].mode, vecs[0].exp);
        step();
        drainWait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
